fifo_alu_sequencer: RTL and testbench

FIFO_ALU_SEQUENCER -- requirements
Module: fifo_alu_sequencer

---
 rtl/fifo_alu_sequencer.sv | 169 ++++++++++++++++
 tb/tb_fifo_alu_sequencer.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_alu_sequencer.sv
// rtl/fifo_alu_sequencer.sv - command-frame sequencer between a byte FIFO and a 16-bit ALU
//
// Pulls 5-byte command frames (opcode, A hi, A lo, B hi, B lo) from a byte FIFO,
// launches the ALU, waits for completion and presents the result on a
// valid/ready channel. One frame is in flight at a time.
//
// Optional feature: define SEQ_TIMEOUT_EN to compile in a WAIT-state watchdog
// that aborts after TIMEOUT_CYCLES cycles with res_timeout=1.
//
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   fifo_rdata, fifo_empty       command FIFO read data (valid cycle after pop), empty flag
//   fifo_rd_en                   command FIFO pop strobe
//   alu_a, alu_b, alu_operation  ALU operands and opcode
//   alu_start                    one-cycle ALU launch pulse
//   alu_result, alu_done,
//   alu_overflow                 ALU return path
//   res_data, res_overflow,
//   res_timeout, res_valid,
//   res_ready                    result channel
//   busy                         frame in progress
//   cmd_count                    completed commands (wraps)

module fifo_alu_sequencer #(
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  fifo_rdata,
   input  logic        fifo_empty,
   output logic        fifo_rd_en,
   output logic [15:0] alu_a,
   output logic [15:0] alu_b,
   output logic [2:0]  alu_operation,
   output logic        alu_start,
   input  logic [15:0] alu_result,
   input  logic        alu_done,
   input  logic        alu_overflow,
   output logic [15:0] res_data,
   output logic        res_overflow,
   output logic        res_timeout,
   output logic        res_valid,
   input  logic        res_ready,
   output logic        busy,
   output logic [7:0]  cmd_count
);

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      OUT   = 2'd3
   } state_t;

   state_t     state;
   logic [2:0] pop_cnt;      // pops issued for the current frame
   logic [2:0] cap_cnt;      // bytes captured for the current frame
   logic       pop_pending;  // a pop was issued last cycle; its byte is on fifo_rdata now

`ifdef SEQ_TIMEOUT_EN
   logic [7:0] wdog;
`endif

   // The pop strobe must react to fifo_empty in the same cycle, so it is
   // decoded from registered state rather than registered itself. rst_n gates
   // it so the strobe is low for the whole reset assertion.
   assign fifo_rd_en = rst_n && (state == FETCH) && !fifo_empty && (pop_cnt < 3'd5);

   assign busy = (state != FETCH) || (cap_cnt != 3'd0);

`ifndef SEQ_TIMEOUT_EN
   assign res_timeout = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= FETCH;
         pop_cnt       <= 3'd0;
         cap_cnt       <= 3'd0;
         pop_pending   <= 1'b0;
         alu_a         <= 16'd0;
         alu_b         <= 16'd0;
         alu_operation <= 3'd0;
         alu_start     <= 1'b0;
         res_data      <= 16'd0;
         res_overflow  <= 1'b0;
         res_valid     <= 1'b0;
         cmd_count     <= 8'd0;
`ifdef SEQ_TIMEOUT_EN
         res_timeout   <= 1'b0;
         wdog          <= 8'd0;
`endif
      end else begin
         pop_pending <= fifo_rd_en;

         case (state)
            FETCH: begin
               if (fifo_rd_en) begin
                  pop_cnt <= pop_cnt + 3'd1;
               end
               // Capture is driven by the pop of the previous cycle, so an
               // empty gap simply stalls both counters with the frame intact.
               if (pop_pending) begin
                  case (cap_cnt)
                     3'd0:    alu_operation <= fifo_rdata[2:0];
                     3'd1:    alu_a[15:8]   <= fifo_rdata;
                     3'd2:    alu_a[7:0]    <= fifo_rdata;
                     3'd3:    alu_b[15:8]   <= fifo_rdata;
                     default: alu_b[7:0]    <= fifo_rdata;
                  endcase
                  if (cap_cnt == 3'd4) begin
                     // pop_cnt is already 5 here, so no pop competes with the clear
                     cap_cnt   <= 3'd0;
                     pop_cnt   <= 3'd0;
                     alu_start <= 1'b1;
                     state     <= ISSUE;
                  end else begin
                     cap_cnt <= cap_cnt + 3'd1;
                  end
               end
            end

            ISSUE: begin
               alu_start <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
               wdog      <= 8'd0;
`endif
               state     <= WAIT;
            end

            WAIT: begin
               if (alu_done) begin
                  res_data     <= alu_result;
                  res_overflow <= alu_overflow;
                  res_valid    <= 1'b1;
`ifdef SEQ_TIMEOUT_EN
                  res_timeout  <= 1'b0;
`endif
                  state        <= OUT;
               end
`ifdef SEQ_TIMEOUT_EN
               // wdog counts WAIT cycles already spent, so expiry is on the
               // TIMEOUT_CYCLES-th cycle; alu_done in that cycle takes the branch above.
               else if (wdog == 8'(TIMEOUT_CYCLES - 1)) begin
                  res_data     <= 16'd0;
                  res_overflow <= 1'b0;
                  res_timeout  <= 1'b1;
                  res_valid    <= 1'b1;
                  state        <= OUT;
               end else begin
                  wdog <= wdog + 8'd1;
               end
`endif
            end

            OUT: begin
               if (res_ready) begin
                  res_valid <= 1'b0;
                  cmd_count <= cmd_count + 8'd1;
                  state     <= FETCH;
               end
            end

            default: state <= FETCH;
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_alu_sequencer.sv
// tb/tb_fifo_alu_sequencer.sv - directed self-checking bench for fifo_alu_sequencer

module tb_fifo_alu_sequencer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  fifo_rdata = 8'd0;
   logic        fifo_empty;
   logic        fifo_rd_en;
   logic [15:0] alu_a, alu_b;
   logic [2:0]  alu_operation;
   logic        alu_start;
   logic [15:0] alu_result;
   logic        alu_done;
   logic        alu_overflow;
   logic [15:0] res_data;
   logic        res_overflow, res_timeout, res_valid;
   logic        res_ready = 1'b0;
   logic        busy;
   logic [7:0]  cmd_count;

   int checks = 0;
   int errors = 0;

   // command FIFO model
   logic [7:0] mem [0:4095];
   int rd_ptr = 0;
   int wr_ptr = 0;
   assign fifo_empty = (rd_ptr >= wr_ptr);

   // ALU model: done follows alu_start by a selectable delay
   logic [7:0]  sh = 8'd0;
   logic        auto_en = 1'b0;
   logic [2:0]  done_idx = 3'd1;
   logic        man_done = 1'b0;
   logic [15:0] ret_val = 16'd0;
   logic        ret_ovf = 1'b0;
   assign alu_done     = man_done | (auto_en & sh[done_idx]);
   assign alu_result   = ret_val;
   assign alu_overflow = ret_ovf;

   // observation log
   int          cyc = 0;
   int          pop_q[$];
   int          start_cyc = -1;
   logic [15:0] st_a, st_b;
   logic [2:0]  st_op;
   int          rd_viol = 0;

   fifo_alu_sequencer #(.TIMEOUT_CYCLES(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .fifo_rdata(fifo_rdata), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
      .alu_a(alu_a), .alu_b(alu_b), .alu_operation(alu_operation), .alu_start(alu_start),
      .alu_result(alu_result), .alu_done(alu_done), .alu_overflow(alu_overflow),
      .res_data(res_data), .res_overflow(res_overflow), .res_timeout(res_timeout),
      .res_valid(res_valid), .res_ready(res_ready),
      .busy(busy), .cmd_count(cmd_count)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (fifo_rd_en) begin
         if (fifo_empty) rd_viol++;
         fifo_rdata <= mem[rd_ptr[11:0]];
         rd_ptr     <= rd_ptr + 1;
         pop_q.push_back(cyc);
      end
      if (alu_start) begin
         start_cyc = cyc;
         st_a      = alu_a;
         st_b      = alu_b;
         st_op     = alu_operation;
      end
      sh <= {sh[6:0], alu_start};
      cyc++;
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_byte(input logic [7:0] b);
      mem[wr_ptr[11:0]] = b;
      wr_ptr++;
   endtask

   task automatic push_frame(input logic [7:0] op, input logic [15:0] a, input logic [15:0] b);
      push_byte(op);
      push_byte(a[15:8]);
      push_byte(a[7:0]);
      push_byte(b[15:8]);
      push_byte(b[7:0]);
   endtask

   task automatic wait_valid(input string tag, input int max);
      int n = 0;
      while (!res_valid && n < max) begin
         tick();
         n++;
      end
      check_eq(tag, res_valid, 1);
   endtask

   task automatic accept();
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      check_eq({tag, "_rd_en"}, fifo_rd_en, 0);
      check_eq({tag, "_alu_a"}, alu_a, 0);
      check_eq({tag, "_alu_b"}, alu_b, 0);
      check_eq({tag, "_alu_op"}, alu_operation, 0);
      check_eq({tag, "_start"}, alu_start, 0);
      check_eq({tag, "_res_data"}, res_data, 0);
      check_eq({tag, "_res_ovf"}, res_overflow, 0);
      check_eq({tag, "_res_to"}, res_timeout, 0);
      check_eq({tag, "_res_valid"}, res_valid, 0);
      check_eq({tag, "_busy"}, busy, 0);
      check_eq({tag, "_cmd_count"}, cmd_count, 0);
   endtask

   initial begin
      int base;
      int bad;
      int bad_rd;

      // reset state, FIFO non-empty so the pop gate is exercised
      push_frame(8'h01, 16'h1234, 16'h0010);
      tick();
      tick();
      check_all_zero("rst");
      rst_n = 1'b1;

      // gapless frame: pops at 0..4, start at 6, done 2 cycles later
      auto_en  = 1'b1;
      done_idx = 3'd1;
      ret_val  = 16'h1244;
      ret_ovf  = 1'b0;
      pop_q.delete();
      base = cyc;
      wait_valid("gapless_valid", 30);
      check_eq("gapless_out_cycle", cyc - base, 9);
      check_eq("gapless_pop_n", pop_q.size(), 5);
      for (int i = 0; i < 5; i++) begin
         if (i < pop_q.size()) check_eq($sformatf("gapless_pop%0d", i), pop_q[i] - base, i);
      end
      check_eq("gapless_start_cycle", start_cyc - base, 6);
      check_eq("gapless_a", st_a, 16'h1234);
      check_eq("gapless_b", st_b, 16'h0010);
      check_eq("gapless_op", st_op, 1);
      check_eq("gapless_data", res_data, 16'h1244);
      check_eq("gapless_ovf", res_overflow, 0);
      check_eq("gapless_to", res_timeout, 0);
      check_eq("gapless_busy", busy, 1);
      accept();
      check_eq("gapless_valid_drop", res_valid, 0);
      check_eq("gapless_count", cmd_count, 1);
      check_eq("gapless_idle_busy", busy, 0);

      // 7-cycle empty gap after byte 2; opcode high bits ignored; done in FETCH ignored
      ret_val = 16'hBEEF;
      ret_ovf = 1'b1;
      pop_q.delete();
      push_byte(8'hF9);
      push_byte(8'h12);
      tick();
      tick();
      bad = 0;
      bad_rd = 0;
      for (int i = 0; i < 7; i++) begin
         man_done = (i == 3);
         if (fifo_rd_en) bad_rd++;
         if (res_valid) bad++;
         tick();
      end
      man_done = 1'b0;
      check_eq("gap_no_pop", bad_rd, 0);
      check_eq("gap_no_valid", bad, 0);
      check_eq("gap_busy", busy, 1);
      push_byte(8'h34);
      push_byte(8'h00);
      push_byte(8'h10);
      wait_valid("gap_valid", 30);
      check_eq("gap_pop_n", pop_q.size(), 5);
      check_eq("gap_a", st_a, 16'h1234);
      check_eq("gap_b", st_b, 16'h0010);
      check_eq("gap_op", st_op, 1);
      check_eq("gap_data", res_data, 16'hBEEF);
      check_eq("gap_ovf", res_overflow, 1);
      accept();
      check_eq("gap_count", cmd_count, 2);

      // backpressure: 10 cycles without ready, next frame waiting in FIFO
      ret_val = 16'h00A5;
      ret_ovf = 1'b0;
      push_frame(8'h02, 16'h0001, 16'h0002);
      wait_valid("bp_valid", 30);
      push_frame(8'h03, 16'h0003, 16'h0004);
      bad = 0;
      bad_rd = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (!res_valid || res_data !== 16'h00A5 || res_overflow !== 1'b0 || cmd_count !== 8'd2) bad++;
         if (fifo_rd_en) bad_rd++;
      end
      check_eq("bp_stable", bad, 0);
      check_eq("bp_no_prefetch", bad_rd, 0);
      accept();
      check_eq("bp_count", cmd_count, 3);
      ret_val = 16'h0007;
      wait_valid("bp_next_valid", 30);
      check_eq("bp_next_a", st_a, 16'h0003);
      check_eq("bp_next_data", res_data, 16'h0007);
      accept();
      check_eq("bp_next_count", cmd_count, 4);

      // done pulse during ISSUE is ignored
      auto_en = 1'b0;
      base = cyc;
      push_frame(8'h05, 16'h0101, 16'h0202);
      for (int i = 0; i < 6; i++) tick();
      check_eq("issue_start", alu_start, 1);
      man_done = 1'b1;
      ret_val  = 16'h9999;
      tick();
      man_done = 1'b0;
      check_eq("issue_start_once", alu_start, 0);
      check_eq("issue_ignored_c7", res_valid, 0);
      tick();
      check_eq("issue_ignored_c8", res_valid, 0);
      ret_val  = 16'h4321;
      man_done = 1'b1;
      tick();
      man_done = 1'b0;
      check_eq("wait_done_valid", res_valid, 1);
      check_eq("wait_done_data", res_data, 16'h4321);
      accept();
      check_eq("issue_count", cmd_count, 5);

`ifdef SEQ_TIMEOUT_EN
      // watchdog expiry after 4 WAIT cycles
      auto_en = 1'b0;
      base = cyc;
      push_frame(8'h04, 16'h1111, 16'h2222);
      for (int i = 0; i < 10; i++) tick();
      check_eq("to_not_yet", res_valid, 0);
      tick();
      check_eq("to_valid", res_valid, 1);
      check_eq("to_flag", res_timeout, 1);
      check_eq("to_data", res_data, 0);
      check_eq("to_ovf", res_overflow, 0);
      accept();
      // done in the expiry cycle wins
      auto_en  = 1'b1;
      done_idx = 3'd3;
      ret_val  = 16'h5555;
      ret_ovf  = 1'b1;
      push_frame(8'h04, 16'h1111, 16'h2222);
      for (int i = 0; i < 11; i++) tick();
      check_eq("race_valid", res_valid, 1);
      check_eq("race_flag", res_timeout, 0);
      check_eq("race_data", res_data, 16'h5555);
      check_eq("race_ovf", res_overflow, 1);
      accept();
      ret_ovf = 1'b0;
`else
      // without watchdog WAIT never gives up
      auto_en = 1'b0;
      push_frame(8'h04, 16'h1111, 16'h2222);
      for (int i = 0; i < 40; i++) tick();
      check_eq("nowd_valid", res_valid, 0);
      check_eq("nowd_to", res_timeout, 0);
      check_eq("nowd_busy", busy, 1);
      ret_val  = 16'h5555;
      man_done = 1'b1;
      tick();
      man_done = 1'b0;
      check_eq("nowd_done_valid", res_valid, 1);
      check_eq("nowd_done_to", res_timeout, 0);
      accept();
`endif

      // asynchronous reset in WAIT, late done ignored, next frame correct
      auto_en  = 1'b0;
      done_idx = 3'd1;
      base = cyc;
      push_frame(8'h05, 16'hFFFF, 16'hEEEE);
      for (int i = 0; i < 7; i++) tick();
      #2;
      rst_n = 1'b0;
      push_frame(8'h06, 16'h0A0B, 16'h0C0D);
      #1;
      check_all_zero("arst");
      tick();
      tick();
      rst_n    = 1'b1;
      man_done = 1'b1;
      tick();
      man_done = 1'b0;
      check_eq("late_done_valid", res_valid, 0);
      auto_en = 1'b1;
      ret_val = 16'h1719;
      wait_valid("post_rst_valid", 30);
      check_eq("post_rst_a", st_a, 16'h0A0B);
      check_eq("post_rst_b", st_b, 16'h0C0D);
      check_eq("post_rst_op", st_op, 6);
      check_eq("post_rst_data", res_data, 16'h1719);
      check_eq("post_rst_count0", cmd_count, 0);
      accept();
      check_eq("post_rst_count1", cmd_count, 1);

      // cmd_count wrap after 256 completed commands
      for (int i = 0; i < 254; i++) begin
         push_frame(8'h07, 16'(i), 16'h0001);
         wait_valid("wrap_valid", 30);
         accept();
      end
      check_eq("wrap_255", cmd_count, 8'hFF);
      push_frame(8'h07, 16'h0000, 16'h0001);
      wait_valid("wrap_last_valid", 30);
      accept();
      check_eq("wrap_0", cmd_count, 8'h00);

      check_eq("rd_en_while_empty", rd_viol, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
